// File: rtl/aes_enc_iter.sv
// aes_enc_iter: iterative AES-128/256 encryption, one round per clock, with on-the-fly key expansion.
// Define AES_ENC_ABORT_EN to add the abort_i port.
module aes_enc_iter #(
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             nreset,
`ifdef AES_ENC_ABORT_EN
    input  logic             abort_i,
`endif
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [127:0]     data_i,
    input  logic [KEY_W-1:0] key_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [127:0]     res_o,
    output logic             busy_o
);
    localparam logic [3:0] NR = (KEY_W == 256) ? 4'd14 : 4'd10;

    if (KEY_W != 128 && KEY_W != 256) begin : g_bad_key_w
        $error("aes_enc_iter: KEY_W must be 128 or 256");
    end

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_w(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] mixw(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    // SubBytes fused with ShiftRows: s'(r,c) = S(s(r,(c+r)%4))
    function automatic logic [127:0] round_f(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
        logic [127:0] sr, mc;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
        for (int c = 0; c < 4; c++)
            mc[127-32*c -: 32] = mixw(sr[127-32*c -: 32]);
        return (last ? sr : mc) ^ rk;
    endfunction

    // Next 4 expanded words from the oldest 4 and the transformed newest word
    function automatic logic [127:0] grp(input logic [127:0] p, input logic [31:0] t);
        logic [31:0] n0, n1, n2, n3;
        n0 = p[127:96] ^ t;
        n1 = p[95:64] ^ n0;
        n2 = p[63:32] ^ n1;
        n3 = p[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    fsm_t             fsm, fsm_nx;
    logic [3:0]       rnd;
    logic [127:0]     state_q, state_nx, rkey;
    logic [KEY_W-1:0] key_q, key_nx;
    logic [7:0]       rcon_q, rcon_nx;
    logic             abrt, fire, last, take;

    if (KEY_W == 256) begin : g_k256
        // window holds words 4(r-1)..4r+3; odd rounds produce an even-indexed group
        logic [31:0] t;
        assign t       = rnd[0] ? (sub_w({key_q[23:0], key_q[31:24]}) ^ {rcon_q, 24'h0})
                                : sub_w(key_q[31:0]);
        assign rkey    = key_q[127:0];
        assign key_nx  = {key_q[127:0], grp(key_q[255:128], t)};
        assign rcon_nx = rnd[0] ? xt(rcon_q) : rcon_q;
    end else begin : g_k128
        assign rkey    = grp(key_q[127:0], sub_w({key_q[23:0], key_q[31:24]}) ^ {rcon_q, 24'h0});
        assign key_nx  = rkey;
        assign rcon_nx = xt(rcon_q);
    end

`ifdef AES_ENC_ABORT_EN
    assign abrt = abort_i & (fsm != IDLE);
`else
    assign abrt = 1'b0;
`endif

    assign in_ready_o = (fsm == IDLE) | ((fsm == DONE) & out_ready_i & ~abrt);
    assign fire       = in_valid_i & in_ready_o;
    assign last       = (fsm == ROUND) & (rnd == NR);
    assign take       = (fsm == DONE) & out_ready_i;
    assign busy_o     = fsm == ROUND;
    assign state_nx   = round_f(state_q, rkey, rnd == NR);

    always_comb begin
        fsm_nx = abrt ? IDLE : fire ? ROUND : last ? DONE : take ? IDLE : fsm;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) fsm <= IDLE;
        else         fsm <= fsm_nx;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rnd         <= 4'd0;
            state_q     <= '0;
            key_q       <= '0;
            rcon_q      <= 8'h00;
            res_o       <= '0;
            out_valid_o <= 1'b0;
        end else begin
            if (fire) begin
                state_q <= data_i ^ key_i[KEY_W-1 -: 128];
                key_q   <= key_i;
                rcon_q  <= 8'h01;
                rnd     <= 4'd1;
            end else if (fsm == ROUND && !abrt) begin
                state_q <= state_nx;
                key_q   <= key_nx;
                rcon_q  <= rcon_nx;
                rnd     <= last ? 4'd0 : rnd + 4'd1;
            end else begin
                rnd <= 4'd0;
            end
            if (last && !abrt) res_o <= state_nx;
            out_valid_o <= abrt ? 1'b0 : last ? 1'b1 : take ? 1'b0 : out_valid_o;
        end
    end
endmodule

// File: tb/tb_aes_enc_iter.sv
// tb_aes_enc_iter: scoreboard bench for aes_enc_iter, one AES-128 and one AES-256 instance.
// Abort checks are included when AES_ENC_ABORT_EN is defined.
module tb_aes_enc_iter;
    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] D_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] D_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         nreset;
    logic         in_valid[2], in_ready[2], out_valid[2], out_ready[2], busy[2];
    logic [127:0] data[2], res[2];
    logic [127:0] key0;
    logic [255:0] key1;
`ifdef AES_ENC_ABORT_EN
    logic         abort0;
`endif

    int           vec = 0, miss = 0, cyc = 0;
    int           fire_cyc[2] = '{0, 0};
    bit           prev_v[2] = '{1'b0, 1'b0};
    logic [127:0] q0[$], q1[$];
    logic [127:0] mon_e;

    aes_enc_iter #(.KEY_W(128)) u_aes128 (
        .clk(clk), .nreset(nreset),
`ifdef AES_ENC_ABORT_EN
        .abort_i(abort0),
`endif
        .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .data_i(data[0]), .key_i(key0),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .res_o(res[0]), .busy_o(busy[0])
    );

    aes_enc_iter #(.KEY_W(256)) u_aes256 (
        .clk(clk), .nreset(nreset),
`ifdef AES_ENC_ABORT_EN
        .abort_i(1'b0),
`endif
        .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .data_i(data[1]), .key_i(key1),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .res_o(res[1]), .busy_o(busy[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Monitor: records fire edges, checks latency on each out_valid rise and pops on handshake
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!nreset) begin
                prev_v[i] = 1'b0;
            end else begin
                if (in_valid[i] && in_ready[i]) fire_cyc[i] = cyc + 1;
                if (out_valid[i] && !prev_v[i])
                    chk($sformatf("latency%0d", i), 128'(cyc - fire_cyc[i]), 128'(i == 1 ? 14 : 10));
                if (out_valid[i] && out_ready[i]) begin
                    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                        vec++;
                        miss++;
                        $display("FAIL result%0d: got unexpected %h required no output", i, res[i]);
                    end else begin
                        mon_e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("result%0d", i), res[i], mon_e);
                    end
                end
                prev_v[i] = out_valid[i];
            end
        end
    end

    task automatic send(input int i, input logic [127:0] pt, input logic [255:0] k);
        int n = 0;
        @(posedge clk); #1;
        in_valid[i] = 1'b1;
        data[i] = pt;
        if (i == 0) key0 = k[255:128];
        else        key1 = k;
        @(negedge clk);
        while (!in_ready[i] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[i]) begin
            vec++;
            miss++;
            $display("FAIL send%0d: in_ready got 0 required 1", i);
        end
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
    endtask

    task automatic wait_out(input int i);
        int n = 0;
        @(negedge clk);
        while (!out_valid[i] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid[i]) begin
            vec++;
            miss++;
            $display("FAIL wait_out%0d: out_valid got 0 required 1", i);
        end
    endtask

    task automatic expect_quiet(input string nm);
        bit seen = 1'b0;
        repeat (16) begin
            @(negedge clk);
            if (out_valid[0]) seen = 1'b1;
        end
        chk(nm, 128'(seen), 128'(0));
    endtask

    initial begin
        nreset = 1'b0;
        key0 = '0;
        key1 = '0;
`ifdef AES_ENC_ABORT_EN
        abort0 = 1'b0;
`endif
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0;
            out_ready[i] = 1'b1;
            data[i] = '0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_in_ready%0d", i), 128'(in_ready[i]), 128'(1));
            chk($sformatf("rst_out_valid%0d", i), 128'(out_valid[i]), 128'(0));
            chk($sformatf("rst_res%0d", i), res[i], 128'(0));
            chk($sformatf("rst_busy%0d", i), 128'(busy[i]), 128'(0));
        end
        @(posedge clk); #1;
        nreset = 1'b1;

        q0.push_back(B_CT);
        send(0, B_PT, {B_KEY, 128'h0});
        wait_out(0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drain_out_valid", 128'(out_valid[0]), 128'(0));
        chk("drain_res_kept", res[0], B_CT);
        chk("drain_in_ready", 128'(in_ready[0]), 128'(1));

        q1.push_back(D_CT);
        send(1, C_PT, D_KEY);
        wait_out(1);
        @(posedge clk); #1;

        out_ready[0] = 1'b0;
        q0.push_back(C_CT);
        send(0, C_PT, {C_KEY, 128'h0});
        wait_out(0);
        for (int k = 0; k < 5; k++) begin
            chk("hold_res", res[0], C_CT);
            chk("hold_in_ready", 128'(in_ready[0]), 128'(0));
            chk("hold_out_valid", 128'(out_valid[0]), 128'(1));
            @(negedge clk);
        end
        @(posedge clk); #1;
        q0.push_back(B_CT);
        in_valid[0] = 1'b1;
        data[0] = B_PT;
        key0 = B_KEY;
        out_ready[0] = 1'b1;
        @(negedge clk);
        chk("b2b_in_ready", 128'(in_ready[0]), 128'(1));
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(negedge clk);
        chk("b2b_busy", 128'(busy[0]), 128'(1));
        wait_out(0);
        @(posedge clk); #1;

        q0.push_back(C_CT);
        send(0, C_PT, {C_KEY, 128'h0});
        @(posedge clk); #1;
        in_valid[0] = 1'b1;
        data[0] = 128'hdeadbeef_00000000_cafef00d_12345678;
        key0 = B_KEY;
        repeat (3) begin
            @(negedge clk);
            chk("ignore_busy", 128'(busy[0]), 128'(1));
            chk("ignore_in_ready", 128'(in_ready[0]), 128'(0));
        end
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        wait_out(0);
        @(posedge clk); #1;

        send(0, B_PT, {B_KEY, 128'h0});
        repeat (4) @(posedge clk);
        #1;
        nreset = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 128'(in_ready[0]), 128'(1));
        chk("midrst_out_valid", 128'(out_valid[0]), 128'(0));
        chk("midrst_res", res[0], 128'(0));
        chk("midrst_busy", 128'(busy[0]), 128'(0));
        @(posedge clk); #1;
        nreset = 1'b1;
        expect_quiet("midrst_no_output");
        q0.push_back(B_CT);
        send(0, B_PT, {B_KEY, 128'h0});
        wait_out(0);
        @(posedge clk); #1;

`ifdef AES_ENC_ABORT_EN
        send(0, C_PT, {C_KEY, 128'h0});
        repeat (2) @(posedge clk);
        #1;
        abort0 = 1'b1;
        in_valid[0] = 1'b1;
        data[0] = B_PT;
        key0 = B_KEY;
        @(posedge clk); #1;
        abort0 = 1'b0;
        in_valid[0] = 1'b0;
        @(negedge clk);
        chk("abort_busy", 128'(busy[0]), 128'(0));
        chk("abort_in_ready", 128'(in_ready[0]), 128'(1));
        expect_quiet("abort_no_output");
        q0.push_back(B_CT);
        send(0, B_PT, {B_KEY, 128'h0});
        wait_out(0);
        @(posedge clk); #1;
`endif

        @(negedge clk);
        chk("queue0_drained", 128'(q0.size()), 128'(0));
        chk("queue1_drained", 128'(q1.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
        $fatal(1);
    end
endmodule
